// File: rtl/stq_ram_pkg.sv
// Shared types and helpers for the multi-port store-queue RAM and its
// clear sequencer.
package stq_ram_pkg;

    // Clear sequencer states: whole-array init, normal operation, and
    // re-clear of a single reactivated partition.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd1,
        RECLR = 2'd2
    } stqState_t;

    localparam int unsigned STQ_DEPTH     = 32;
    localparam int unsigned STQ_NUM_PARTS = 4;

    // Number of entries covered by one LSQ partition.
    function automatic int unsigned partSize(input int unsigned depth,
                                             input int unsigned numParts);
        return depth / numParts;
    endfunction

    // Partition owning an entry; partitions are power-of-2 sized and
    // contiguous, so this is just a shift.
    function automatic int unsigned partOf(input int unsigned addr,
                                           input int unsigned partLog2);
        return addr >> partLog2;
    endfunction

endpackage

// File: rtl/stq_ram_mp_if.sv
// Port bundle between the LSQ control logic and the store-queue RAM.
interface stq_ram_mp_if #(
    parameter int unsigned INDEX     = 5,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned NUM_PARTS = 4
);
    logic [NUM_PARTS-1:0]             partActive_i;
    logic [NUM_RD-1:0][INDEX-1:0]     rdAddr_i;
    logic [NUM_RD-1:0][WIDTH-1:0]     rdData_o;
    logic [NUM_WR-1:0][INDEX-1:0]     wrAddr_i;
    logic [NUM_WR-1:0][WIDTH-1:0]     wrData_i;
    logic [NUM_WR-1:0]                wrEn_i;
    logic                             ramReady_o;

    modport master (
        output partActive_i, rdAddr_i, wrAddr_i, wrData_i, wrEn_i,
        input  rdData_o, ramReady_o
    );

    modport slave (
        input  partActive_i, rdAddr_i, wrAddr_i, wrData_i, wrEn_i,
        output rdData_o, ramReady_o
    );
endinterface

// File: rtl/stq_ram_clr_seq.sv
// Clear sequencer: walks the whole array after reset, then re-clears any
// partition that comes back from gating, one entry per cycle.
module stq_ram_clr_seq
    import stq_ram_pkg::*;
#(
    parameter int unsigned DEPTH     = STQ_DEPTH,
    parameter int unsigned INDEX     = 5,
    parameter int unsigned NUM_PARTS = STQ_NUM_PARTS,
    parameter int unsigned PART_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PARTS-1:0]  i_partActive,
    output logic                  o_clrEn,
    output logic [INDEX-1:0]      o_clrAddr,
    output logic [PART_W-1:0]     o_clrPart,
    output stqState_t             o_state,
    output logic                  o_ramReady
);

    localparam int unsigned      PART_SZ       = partSize(DEPTH, NUM_PARTS);
    localparam int unsigned      PART_LOG2     = $clog2(PART_SZ);
    localparam logic [INDEX-1:0] LAST_ENTRY    = INDEX'(DEPTH - 1);
    localparam logic [INDEX-1:0] PART_LAST_OFS = INDEX'(PART_SZ - 1);

    stqState_t              r_state;
    logic [INDEX-1:0]       r_cnt;
    logic [NUM_PARTS-1:0]   r_pending;
    logic [NUM_PARTS-1:0]   r_prevActive;
    logic [PART_W-1:0]      r_clrPart;
    logic                   r_ready;

    stqState_t              w_stateNext;
    logic [INDEX-1:0]       w_cntNext;
    logic [NUM_PARTS-1:0]   w_pendAcc;
    logic [NUM_PARTS-1:0]   w_pendNext;
    logic [PART_W-1:0]      w_partNext;
    logic                   w_clrEn;
    logic                   w_pick;
    logic                   w_readyNext;

    function automatic logic [PART_W-1:0] lowestSet(input logic [NUM_PARTS-1:0] mask);
        logic [PART_W-1:0] idx;
        idx = '0;
        for (int p = NUM_PARTS - 1; p >= 0; p--) begin
            if (mask[p]) idx = PART_W'(p);
        end
        return idx;
    endfunction

    function automatic logic [INDEX-1:0] partBase(input logic [PART_W-1:0] part);
        return INDEX'(INDEX'(part) << PART_LOG2);
    endfunction

    // Next-state logic: rising partActive bits join the pending set, and
    // whenever a clear finishes or aborts the lowest pending partition is
    // started immediately so back-to-back clears have no idle cycle.
    always_comb begin
        w_pendAcc   = r_pending | (i_partActive & ~r_prevActive);
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_pendNext  = w_pendAcc;
        w_partNext  = r_clrPart;
        w_clrEn     = 1'b0;
        w_pick      = 1'b0;
        case (r_state)
            INIT: begin
                w_clrEn = 1'b1;
                if (r_cnt == LAST_ENTRY) begin
                    w_stateNext = READY;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + INDEX'(1);
                end
            end
            READY: begin
                w_pick = 1'b1;
            end
            RECLR: begin
                if (!i_partActive[r_clrPart]) begin
                    w_pendNext[r_clrPart] = 1'b0;
                    w_pick                = 1'b1;
                end else begin
                    w_clrEn = 1'b1;
                    if (r_cnt == (partBase(r_clrPart) | PART_LAST_OFS)) begin
                        w_pendNext[r_clrPart] = 1'b0;
                        w_pick                = 1'b1;
                    end else begin
                        w_cntNext = r_cnt + INDEX'(1);
                    end
                end
            end
            default: begin
                w_stateNext = INIT;
                w_cntNext   = '0;
            end
        endcase
        if (w_pick) begin
            if (w_pendNext != '0) begin
                w_stateNext = RECLR;
                w_partNext  = lowestSet(w_pendNext);
                w_cntNext   = partBase(w_partNext);
            end else begin
                w_stateNext = READY;
            end
        end
        w_readyNext = (w_stateNext == READY) && (w_pendNext == '0);
    end

    // Sequencer registers; reset always restarts the full init walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= INIT;
            r_cnt        <= '0;
            r_pending    <= '0;
            r_prevActive <= i_partActive;
            r_clrPart    <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_cnt        <= w_cntNext;
            r_pending    <= w_pendNext;
            r_prevActive <= i_partActive;
            r_clrPart    <= w_partNext;
            r_ready      <= w_readyNext;
        end
    end

    assign o_clrEn    = w_clrEn;
    assign o_clrAddr  = r_cnt;
    assign o_clrPart  = r_clrPart;
    assign o_state    = r_state;
    assign o_ramReady = r_ready;

endmodule

// File: rtl/stq_ram_mp.sv
// Multi-port store-queue RAM with partition gating, write-port priority,
// optional write-to-read bypass and a self-clearing init/re-clear sequencer.
module stq_ram_mp
    import stq_ram_pkg::*;
#(
    parameter int unsigned       DEPTH     = STQ_DEPTH,
    parameter int unsigned       INDEX     = 5,
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       NUM_RD    = 2,
    parameter int unsigned       NUM_WR    = 2,
    parameter int unsigned       NUM_PARTS = STQ_NUM_PARTS,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter int unsigned       BYPASS    = 0
) (
    input  logic          clk,
    input  logic          reset,
    stq_ram_mp_if.slave   bus
);

    localparam int unsigned PART_SZ   = partSize(DEPTH, NUM_PARTS);
    localparam int unsigned PART_LOG2 = $clog2(PART_SZ);
    localparam int unsigned PART_W    = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;

    logic [WIDTH-1:0]              r_mem [DEPTH];

    logic                          w_clrEn;
    logic [INDEX-1:0]              w_clrAddr;
    logic [PART_W-1:0]             w_clrPart;
    stqState_t                     w_state;
    logic                          w_ramReady;
    logic [NUM_WR-1:0]             w_wrOk;
    logic [NUM_RD-1:0][WIDTH-1:0]  w_rdData;

    function automatic logic [PART_W-1:0] partIdx(input logic [INDEX-1:0] addr);
        return PART_W'(partOf(32'(addr), PART_LOG2));
    endfunction

    stq_ram_clr_seq #(
        .DEPTH     (DEPTH),
        .INDEX     (INDEX),
        .NUM_PARTS (NUM_PARTS),
        .PART_W    (PART_W)
    ) u_clrSeq (
        .clk          (clk),
        .reset        (reset),
        .i_partActive (bus.partActive_i),
        .o_clrEn      (w_clrEn),
        .o_clrAddr    (w_clrAddr),
        .o_clrPart    (w_clrPart),
        .o_state      (w_state),
        .o_ramReady   (w_ramReady)
    );

    // A write commits only outside init, to an active partition, and never
    // into the partition currently being re-cleared.
    always_comb begin
        w_wrOk = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            w_wrOk[w] = bus.wrEn_i[w] && !reset && (w_state != INIT)
                        && bus.partActive_i[partIdx(bus.wrAddr_i[w])]
                        && !((w_state == RECLR) && (partIdx(bus.wrAddr_i[w]) == w_clrPart));
        end
    end

    // Array update: ascending port order lets the highest port win an
    // address conflict, and the clear write comes last so it beats them all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wrOk[w]) r_mem[bus.wrAddr_i[w]] <= bus.wrData_i[w];
            end
            if (w_clrEn) r_mem[w_clrAddr] <= RESET_VAL;
        end
    end

    // Read path: array contents, optionally overridden by a same-cycle
    // committing write, and forced to the reset value while initialising
    // or when the addressed partition is gated.
    always_comb begin
        w_rdData = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            w_rdData[r] = r_mem[bus.rdAddr_i[r]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (w_wrOk[w] && (bus.wrAddr_i[w] == bus.rdAddr_i[r])) begin
                        w_rdData[r] = bus.wrData_i[w];
                    end
                end
            end
            if ((w_state == INIT) || !bus.partActive_i[partIdx(bus.rdAddr_i[r])]) begin
                w_rdData[r] = RESET_VAL;
            end
        end
    end

    assign bus.rdData_o   = w_rdData;
    assign bus.ramReady_o = w_ramReady;

endmodule

// File: tb/tb_stq_ram_mp.sv
// Scoreboard bench for stq_ram_mp: two instances (bypass off / on) share one
// stimulus stream; a behavioural model predicts reads and ready per cycle.
module tb_stq_ram_mp;
    import stq_ram_pkg::*;

    localparam int DEPTH     = 32;
    localparam int INDEX     = 5;
    localparam int WIDTH     = 8;
    localparam int NUM_RD    = 2;
    localparam int NUM_WR    = 2;
    localparam int NUM_PARTS = 4;
    localparam int PSZ       = DEPTH / NUM_PARTS;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [NUM_PARTS-1:0]          partActive;
    logic [NUM_RD-1:0][INDEX-1:0]  rdAddr;
    logic [NUM_WR-1:0][INDEX-1:0]  wrAddr;
    logic [NUM_WR-1:0][WIDTH-1:0]  wrData;
    logic [NUM_WR-1:0]             wrEn;

    int   compared   = 0;
    int   mismatched = 0;
    bit   skipChecks = 1'b1;
    exp_t expQ[$];

    int       mem [DEPTH];
    int       initLeft;
    bit [3:0] pend;
    bit [3:0] prev;
    int       cur;
    int       off;
    bit       mReady;

    always #5 clk = ~clk;

    stq_ram_mp_if #(.INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                    .NUM_PARTS(NUM_PARTS)) busN ();
    stq_ram_mp_if #(.INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                    .NUM_PARTS(NUM_PARTS)) busB ();

    assign busN.partActive_i = partActive;
    assign busN.rdAddr_i     = rdAddr;
    assign busN.wrAddr_i     = wrAddr;
    assign busN.wrData_i     = wrData;
    assign busN.wrEn_i       = wrEn;
    assign busB.partActive_i = partActive;
    assign busB.rdAddr_i     = rdAddr;
    assign busB.wrAddr_i     = wrAddr;
    assign busB.wrData_i     = wrData;
    assign busB.wrEn_i       = wrEn;

    stq_ram_mp #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NUM_RD),
                 .NUM_WR(NUM_WR), .NUM_PARTS(NUM_PARTS), .RESET_VAL(8'h00), .BYPASS(0))
        dutN (.clk(clk), .reset(reset), .bus(busN.slave));

    stq_ram_mp #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NUM_RD),
                 .NUM_WR(NUM_WR), .NUM_PARTS(NUM_PARTS), .RESET_VAL(8'h00), .BYPASS(1))
        dutB (.clk(clk), .reset(reset), .bus(busB.slave));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A write lands if the array is out of init, its partition is active
    // and that partition is not the one being re-cleared.
    function automatic bit wrCommits(input int w);
        int p;
        p = int'(wrAddr[w]) / PSZ;
        return wrEn[w] && (initLeft == 0) && partActive[p] && (cur != p);
    endfunction

    function automatic int expRead(input int r, input bit bypass);
        int a;
        int v;
        a = int'(rdAddr[r]);
        if (initLeft > 0 || !partActive[a / PSZ]) return 0;
        v = mem[a];
        if (bypass) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wrCommits(w) && int'(wrAddr[w]) == a) v = int'(wrData[w]);
            end
        end
        return v;
    endfunction

    function automatic void pickNext();
        for (int p = 0; p < NUM_PARTS; p++) begin
            if (pend[p]) begin
                cur = p;
                off = 0;
                return;
            end
        end
    endfunction

    function automatic void modelEdge();
        if (reset) begin
            initLeft = DEPTH;
            pend     = '0;
            prev     = partActive;
            cur      = -1;
            off      = 0;
            mReady   = 1'b0;
            return;
        end
        pend = pend | (partActive & ~prev);
        prev = partActive;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wrCommits(w)) mem[int'(wrAddr[w])] = int'(wrData[w]);
        end
        if (initLeft > 0) begin
            mem[DEPTH - initLeft] = 0;
            initLeft--;
        end else if (cur >= 0) begin
            if (!partActive[cur]) begin
                pend[cur] = 1'b0;
                cur = -1;
                pickNext();
            end else begin
                mem[cur * PSZ + off] = 0;
                off++;
                if (off == PSZ) begin
                    pend[cur] = 1'b0;
                    cur = -1;
                    pickNext();
                end
            end
        end else begin
            pickNext();
        end
        mReady = (initLeft == 0) && (pend == '0);
    endfunction

    function automatic void pushExp(input int kind, input int port, input int val, input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = 32'(val);
        e.name = name;
        expQ.push_back(e);
    endfunction

    // Directed constant expectation for the current cycle.
    function automatic void expectConst(input string name, input int kind, input int port, input int val);
        pushExp(kind, port, val, name);
    endfunction

    task automatic applyStimulus(input int ra0, input int ra1,
                                 input int wa0, input int wd0, input bit we0,
                                 input int wa1, input int wd1, input bit we1);
        rdAddr[0] = 5'(ra0);
        rdAddr[1] = 5'(ra1);
        wrAddr[0] = 5'(wa0);
        wrData[0] = 8'(wd0);
        wrEn[0]   = we0;
        wrAddr[1] = 5'(wa1);
        wrData[1] = 8'(wd1);
        wrEn[1]   = we1;
    endtask

    task automatic tick();
        if (!skipChecks) begin
            pushExp(2, 0, int'(mReady), "readyN");
            pushExp(3, 0, int'(mReady), "readyB");
            if (!reset) begin
                for (int r = 0; r < NUM_RD; r++) begin
                    pushExp(0, r, expRead(r, 1'b0), $sformatf("rdN%0d", r));
                    pushExp(1, r, expRead(r, 1'b1), $sformatf("rdB%0d", r));
                end
            end
        end
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic ticksUntilReady(output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (busN.ramReady_o === 1'b1) break;
        end
    endtask

    task automatic readRange(input string name, input int lo, input int hi, input int val);
        for (int a = lo; a <= hi; a += 2) begin
            applyStimulus(a, a + 1, 0, 0, 0, 0, 0, 0);
            expectConst(name, 0, 0, val);
            expectConst(name, 0, 1, val);
            tick();
        end
    endtask

    // Monitor: drains every expectation issued for this cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            case (e.kind)
                0:       act = 32'(busN.rdData_o[e.port]);
                1:       act = 32'(busB.rdData_o[e.port]);
                2:       act = 32'(busN.ramReady_o);
                default: act = 32'(busB.ramReady_o);
            endcase
            checkOutput(e.name, act, e.exp);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        initLeft = DEPTH; pend = '0; prev = '1; cur = -1; off = 0; mReady = 1'b0;
        reset = 1'b1;
        partActive = 4'hF;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        skipChecks = 1'b0;
        tick();

        $display("[TB] post-reset init");
        reset = 1'b0;
        ticksUntilReady(n);
        checkOutput("initReadyCycles", 32'(n), 32'd32);
        readRange("initClear", 0, DEPTH - 1, 0);

        $display("[TB] write conflict and separate writes");
        applyStimulus(0, 0, 5, 8'hAA, 1, 5, 8'h55, 1);
        tick();
        applyStimulus(5, 0, 3, 8'h11, 1, 7, 8'h22, 1);
        expectConst("conflictAddr5", 0, 0, 8'h55);
        tick();
        applyStimulus(3, 7, 0, 0, 0, 0, 0, 0);
        expectConst("sepAddr3", 0, 0, 8'h11);
        expectConst("sepAddr7", 0, 1, 8'h22);
        tick();

        $display("[TB] bypass");
        applyStimulus(9, 0, 9, 8'h3C, 1, 0, 0, 0);
        expectConst("bypassOn", 1, 0, 8'h3C);
        expectConst("bypassOffOld", 0, 0, 8'h00);
        tick();
        applyStimulus(9, 0, 0, 0, 0, 0, 0, 0);
        expectConst("bypassOffNext", 0, 0, 8'h3C);
        tick();

        $display("[TB] gating");
        applyStimulus(0, 0, 10, 8'h77, 1, 2, 8'h44, 1);
        tick();
        partActive = 4'b1101;
        applyStimulus(10, 12, 12, 8'h99, 1, 0, 0, 0);
        expectConst("gatedRead10", 0, 0, 0);
        expectConst("gatedRead10B", 1, 0, 0);
        tick();
        applyStimulus(2, 12, 0, 0, 0, 0, 0, 0);
        expectConst("ungatedAddr2", 0, 0, 8'h44);
        expectConst("gatedRead12", 0, 1, 0);
        tick();
        partActive = 4'b1111;
        applyStimulus(2, 10, 0, 0, 0, 0, 0, 0);
        ticksUntilReady(n);
        checkOutput("reclrLowCycles", 32'(n - 1), 32'd8);
        readRange("reclrPart1", 8, 15, 0);
        applyStimulus(2, 0, 0, 0, 0, 0, 0, 0);
        expectConst("reclrKeepAddr2", 0, 0, 8'h44);
        tick();

        $display("[TB] simultaneous reactivation");
        applyStimulus(0, 0, 9, 8'h5A, 1, 25, 8'hA5, 1);
        tick();
        partActive = 4'b0101;
        applyStimulus(9, 25, 0, 0, 0, 0, 0, 0);
        tick();
        partActive = 4'b1111;
        ticksUntilReady(n);
        checkOutput("dualReclrLowCycles", 32'(n - 1), 32'd16);
        expectConst("dualAddr9", 0, 0, 0);
        expectConst("dualAddr25", 0, 1, 0);
        tick();

        $display("[TB] abort of an in-progress clear");
        applyStimulus(17, 21, 17, 8'h12, 1, 21, 8'h34, 1);
        tick();
        partActive = 4'b1011;
        applyStimulus(17, 21, 0, 0, 0, 0, 0, 0);
        tick();
        partActive = 4'b1111;
        repeat (3) tick();
        partActive = 4'b1011;
        repeat (2) tick();
        partActive = 4'b1111;
        ticksUntilReady(n);

        $display("[TB] reset mid re-clear");
        applyStimulus(20, 0, 20, 8'h66, 1, 0, 0, 0);
        tick();
        partActive = 4'b1011;
        applyStimulus(20, 0, 0, 0, 0, 0, 0, 0);
        tick();
        partActive = 4'b1111;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        ticksUntilReady(n);
        checkOutput("resetMidReclrInit", 32'(n), 32'd32);
        readRange("resetMidReclrClear", 0, DEPTH - 1, 0);

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) partActive[$urandom_range(0, 3)] ^= 1'b1;
            for (int w = 0; w < NUM_WR; w++) begin
                wrEn[w]   = 1'($urandom_range(0, 1));
                wrAddr[w] = 5'($urandom);
                wrData[w] = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) wrAddr[1] = wrAddr[0];
            for (int r = 0; r < NUM_RD; r++) begin
                rdAddr[r] = ($urandom_range(0, 2) == 0) ? wrAddr[$urandom_range(0, 1)] : 5'($urandom);
            end
            tick();
        end
        reset = 1'b0;
        partActive = 4'hF;
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        ticksUntilReady(n);
        for (int a = 0; a < DEPTH; a += 2) begin
            applyStimulus(a, a + 1, 0, 0, 0, 0, 0, 0);
            tick();
        end

        @(negedge clk);
        #1;
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stq_ram_mp.md
Name: stq_ram_mp

Overview:
- Parametrised multi-port store-queue RAM; successor to the fixed 2-read/1-write STQ array.
- Adds configurable read/write port counts, write-conflict resolution and optional write-to-read bypass.
- Adds LSQ partition gating with hardware re-clear on partition reactivation, and a self-clearing init sequencer that drives a ready flag.
- Sits in the LSU store path; the LSQ control logic consumes ramReady_o.

Parameters:
- DEPTH, 32, number of entries; power of 2, divisible by NUM_PARTS.
- INDEX, 5, address width; must equal log2(DEPTH).
- WIDTH, 8, entry width in bits.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- NUM_PARTS, 4, number of LSQ partitions; power of 2.
- RESET_VAL, 0, value written to every entry on clear.
- BYPASS, 0, 1 = a same-cycle write is forwarded to a matching read.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- partActive_i  in  NUM_PARTS  per-partition active mask; bit p covers entries [p*DEPTH/NUM_PARTS, (p+1)*DEPTH/NUM_PARTS).
- rdAddr_i  in  NUM_RD x INDEX  read addresses.
- rdData_o  out  NUM_RD x WIDTH  read data; combinational.
- wrAddr_i  in  NUM_WR x INDEX  write addresses.
- wrData_i  in  NUM_WR x WIDTH  write data.
- wrEn_i  in  NUM_WR  write enables.
- ramReady_o  out  1  array is initialised and no partition re-clear is pending.

Behaviour:
- Registered state is the array, FSM state, clear counter, pending-clear mask and prevActive register.
- Reset: FSM=INIT, counter=0, pending=0, prevActive=partActive_i. ramReady_o=0 during reset and the following cycles.
- INIT state:
  - Each cycle writes RESET_VAL to entry[counter] and increments counter.
  - After entry DEPTH-1 is written, moves to READY. ramReady_o=1 from the next cycle, i.e. DEPTH cycles after reset deasserts.
- During INIT, external writes are dropped and every rdData_o = RESET_VAL.
- READY state:
  - Each write port with wrEn_i=1 whose target partition is active writes its data at posedge.
  - Same-address conflict: the highest-numbered enabled port wins.
  - A write to a gated partition is dropped.
- Reads:
  - rdData_o[r] = RESET_VAL if the addressed partition is gated; otherwise the array contents.
  - If BYPASS=1 and an active write targets the same address this cycle, rdData_o[r] returns that write data (highest-numbered port on conflict).
  - BYPASS=0 returns the pre-write value.
- Reactivation:
  - Each cycle, pending |= partActive_i & ~prevActive; then prevActive <= partActive_i.
  - With pending nonzero in READY, the FSM goes to RECLR on the lowest set bit p. Counter starts at the partition base and clears DEPTH/NUM_PARTS entries, one per cycle.
  - ramReady_o=0 from the cycle after the 0->1 edge until pending is empty.
  - External writes to partition p during its RECLR are dropped; writes to other active partitions proceed. A same-cycle write to the entry being cleared loses to the clear.
  - Multiple partitions are handled in ascending index order, back-to-back with no idle cycle.
- Deactivation of a partition mid-RECLR aborts its clear and drops its pending bit. The FSM then goes to the next pending partition, or to READY.
- Reset asserted in any state restarts INIT at counter 0, regardless of progress.
- The counter wraps only inside its clear range; no address outside the range is touched.

Decomposition:
- Shared package stq_ram_pkg: FSM state enum (INIT, READY, RECLR), helper constant PART_SZ = DEPTH/NUM_PARTS, and a partition-index function (addr >> log2(PART_SZ)).
- One sub-module, stq_ram_clr_seq, holds the FSM, counter, pending mask and ready flag. It outputs clrEn, clrAddr and the in-clear partition.
- The top level holds the array, write-priority mux, bypass and gating logic.

Test Plan:
- Post-reset init: deassert reset, poll ramReady_o -> rises exactly 32 cycles later; every entry reads 0.
- Write conflict: wr0 (addr 5, 0xAA) and wr1 (addr 5, 0x55) in the same cycle -> addr 5 reads 0x55. Separate writes (addr 3, 0x11) and (addr 7, 0x22) -> both stored.
- Bypass: BYPASS=1, write addr 9 = 0x3C while rd0 reads addr 9 -> 0x3C in that cycle. With BYPASS=0 -> old value, then 0x3C next cycle.
- Gating:
  - Write entry 10 = 0x77, then set partActive=4'b1101 -> read addr 10 returns 0, and a write to addr 12 is dropped.
  - Re-set partActive=4'b1111 -> ramReady_o low 8 cycles, entries 8-15 read 0, entry 2 unchanged.
- Simultaneous reactivation: partitions 1 and 3 re-enabled in the same cycle -> ramReady_o low 16 consecutive cycles; partition 1 entries cleared before partition 3.
- Reset mid-RECLR: assert reset 3 cycles into a partition clear -> full 32-cycle INIT, then ramReady_o=1 and all entries read 0.
